// File: rtl/cache.sv
// cache: 16-set, 2-way set-associative cache with 4-byte lines and a 10-bit tag.
// Write-allocate with no backing store; reads never allocate. Every access
// completes in one clock and its result is registered.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   enableread   perform a read this cycle
//   enablewrite  perform a write this cycle (both high together = no-op)
//   address      [15:6] tag, [5:2] set index, [1:0] read byte select
//   datain       write data byte
//   writebyte    byte lane written (address[1:0] is ignored on writes)
//   dataout      registered read data; holds its value on writes and no-ops
//   hitmiss      registered hit flag, 1 = hit
module cache (
  input  logic        clk,
  input  logic        reset,
  input  logic        enableread,
  input  logic        enablewrite,
  input  logic [15:0] address,
  input  logic [7:0]  datain,
  input  logic [1:0]  writebyte,
  output logic [7:0]  dataout,
  output logic        hitmiss
);

  logic [1:0] r_valid [16];
  logic [9:0] r_tag   [16][2];
  logic [7:0] r_data  [16][2][4];
  // Per-set way to replace next.
  logic [15:0] r_lru;

  logic [9:0] w_tag;
  logic [3:0] w_set;
  logic       w_hit0;
  logic       w_hit1;
  logic       w_hit;
  logic       w_hit_way;
  logic       w_victim;

  assign w_tag     = address[15:6];
  assign w_set     = address[5:2];
  assign w_hit0    = r_valid[w_set][0] && (r_tag[w_set][0] == w_tag);
  assign w_hit1    = r_valid[w_set][1] && (r_tag[w_set][1] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1;

  // An empty way wins over the LRU way; way 0 is tried first.
  always_comb begin
    w_victim = r_lru[w_set];
    if (!r_valid[w_set][0]) begin
      w_victim = 1'b0;
    end else if (!r_valid[w_set][1]) begin
      w_victim = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < 16; s++) begin
        r_valid[s] <= '0;
        for (int unsigned w = 0; w < 2; w++) begin
          r_tag[s][w] <= '0;
          for (int unsigned b = 0; b < 4; b++) begin
            r_data[s][w][b] <= '0;
          end
        end
      end
      r_lru   <= '0;
      dataout <= '0;
      hitmiss <= 1'b0;
    end else if (enableread && !enablewrite) begin
      if (w_hit) begin
        dataout        <= r_data[w_set][w_hit_way][address[1:0]];
        hitmiss        <= 1'b1;
        r_lru[w_set]   <= ~w_hit_way;
      end else begin
        dataout <= '0;
        hitmiss <= 1'b0;
      end
    end else if (enablewrite && !enableread) begin
      if (w_hit) begin
        r_data[w_set][w_hit_way][writebyte] <= datain;
        hitmiss      <= 1'b1;
        r_lru[w_set] <= ~w_hit_way;
      end else begin
        r_valid[w_set][w_victim] <= 1'b1;
        r_tag[w_set][w_victim]   <= w_tag;
        // Allocation clears the whole line and writes one lane in the same edge.
        for (int unsigned b = 0; b < 4; b++) begin
          r_data[w_set][w_victim][b] <= (2'(b) == writebyte) ? datain : '0;
        end
        hitmiss      <= 1'b0;
        r_lru[w_set] <= ~w_victim;
      end
    end
  end

endmodule

// File: tb/tb_cache.sv
module tb_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enableread = 1'b0;
  logic        enablewrite = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  datain = '0;
  logic [1:0]  writebyte = '0;
  logic [7:0]  dataout;
  logic        hitmiss;

  always #5 clk = ~clk;

  cache dut (
    .clk         (clk),
    .reset       (reset),
    .enableread  (enableread),
    .enablewrite (enablewrite),
    .address     (address),
    .datain      (datain),
    .writebyte   (writebyte),
    .dataout     (dataout),
    .hitmiss     (hitmiss)
  );

  // Reference model: per set, two slots holding (valid, tag, 4 bytes) plus
  // the index of the slot to give up next.
  bit          m_valid [16][2];
  int          m_tag   [16][2];
  logic [7:0]  m_data  [16][2][4];
  int          m_next  [16];
  logic [7:0]  m_dout;
  bit          m_hit;

  logic [8:0]  exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        done = 1'b0;

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_next[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_tag[s][w] = 0;
        for (int b = 0; b < 4; b++) m_data[s][w][b] = 8'h00;
      end
    end
    m_dout = 8'h00;
    m_hit = 0;
  endtask

  task automatic model_access(input bit rd, input bit wr, input logic [15:0] a,
                              input logic [7:0] d, input logic [1:0] wb);
    int s, t, found, v;
    if (rd == wr) return;
    s = int'(a[5:2]);
    t = int'(a[15:6]);
    found = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) found = w;
    if (rd) begin
      if (found >= 0) begin
        m_dout = m_data[s][found][a[1:0]];
        m_hit = 1;
        m_next[s] = 1 - found;
      end else begin
        m_dout = 8'h00;
        m_hit = 0;
      end
    end else begin
      if (found >= 0) begin
        m_data[s][found][wb] = d;
        m_hit = 1;
        m_next[s] = 1 - found;
      end else begin
        if (!m_valid[s][0]) v = 0;
        else if (!m_valid[s][1]) v = 1;
        else v = m_next[s];
        m_valid[s][v] = 1;
        m_tag[s][v] = t;
        for (int b = 0; b < 4; b++) m_data[s][v][b] = 8'h00;
        m_data[s][v][wb] = d;
        m_hit = 0;
        m_next[s] = 1 - v;
      end
    end
  endtask

  // Called at a falling edge: drive one request, queue its expected result,
  // and return at the next falling edge.
  task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                    input logic [7:0] d, input logic [1:0] wb);
    enableread = rd;
    enablewrite = wr;
    address = a;
    datain = d;
    writebyte = wb;
    model_access(rd, wr, a, d, wb);
    exp_q.push_back({m_dout, m_hit});
    @(negedge clk);
    enableread = 1'b0;
    enablewrite = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reset dropped while a read is being presented, before its clock edge.
  task automatic reset_mid_read(input logic [15:0] a);
    enableread = 1'b1;
    address = a;
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    enableread = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: checks outputs after every clock edge, and immediately after reset falls.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk or negedge reset or posedge done);
      #1;
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end else if (!reset) begin
        n_checks++;
        if (dataout == 8'h00 && hitmiss == 1'b0) n_pass++;
        else $display("FAIL reset_out: got dataout=%h hitmiss=%b, required 00/0 at %0t",
                      dataout, hitmiss, $time);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL no_expect: edge at %0t with no queued expectation", $time);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (dataout === e[8:1] && hitmiss === e[0]) n_pass++;
        else $display("FAIL resp addr=%h: got dataout=%h hitmiss=%b, required %h/%b at %0t",
                      address, dataout, hitmiss, e[8:1], e[0], $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    logic [15:0] a;
    model_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fill sets 0..14, then read back set 0 lanes.
    for (int idx = 0; idx < 15; idx++)
      for (int b = 0; b < 4; b++)
        op(0, 1, 16'(idx * 4), 8'(idx * 4 + b), 2'(b));
    for (int b = 0; b < 4; b++) op(1, 0, 16'(b), 8'h00, 2'd0);

    // Repeated reads, lane overwrite, repeated reads.
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    for (int b = 0; b < 4; b++) op(0, 1, 16'h0000, 8'h01, 2'(b));
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    op(1, 0, 16'h0000, 8'h00, 2'd0);

    // Cold miss, allocate, hit, other lane of the same line.
    pulse_reset();
    op(1, 0, 16'hFFFF, 8'h00, 2'd0);
    op(0, 1, 16'hFFFF, 8'd42, 2'd3);
    op(1, 0, 16'hFFFF, 8'h00, 2'd0);
    op(1, 0, 16'hFFFC, 8'h00, 2'd0);

    // Two tags in set 0, recency decides the eviction.
    pulse_reset();
    op(0, 1, 16'h0000, 8'h11, 2'd0);
    op(0, 1, 16'h0040, 8'h22, 2'd0);
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    op(1, 0, 16'h0040, 8'h00, 2'd0);
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    op(0, 1, 16'h0080, 8'h33, 2'd0);
    op(1, 0, 16'h0040, 8'h00, 2'd0);
    op(1, 0, 16'h0000, 8'h00, 2'd0);
    op(1, 0, 16'h0080, 8'h00, 2'd0);

    // Writes to set 1 leave sets 0 and 2 alone.
    op(0, 1, 16'h0000, 8'hAA, 2'd1);
    op(0, 1, 16'h0008, 8'h55, 2'd2);
    for (int b = 0; b < 4; b++) op(0, 1, 16'h0004, 8'h0F, 2'(b));
    op(1, 0, 16'h0001, 8'h00, 2'd0);
    op(1, 0, 16'h000A, 8'h00, 2'd0);
    op(1, 0, 16'h0007, 8'h00, 2'd0);

    // Idle and both-enables cycles hold outputs and change nothing.
    op(0, 0, 16'h0001, 8'h77, 2'd1);
    op(1, 1, 16'h0000, 8'h77, 2'd1);
    op(0, 1, 16'h0000, 8'h99, 2'd3);
    op(1, 1, 16'h0000, 8'h77, 2'd3);
    op(1, 0, 16'h0001, 8'h00, 2'd0);
    op(1, 0, 16'h0003, 8'h00, 2'd0);

    // Reset during an access: everything misses afterwards.
    reset_mid_read(16'h0001);
    op(1, 0, 16'h0001, 8'h00, 2'd0);
    op(1, 0, 16'h000A, 8'h00, 2'd0);
    op(1, 0, 16'h0080, 8'h00, 2'd0);

    // Random traffic over a few tags so both hits and evictions are common.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid_read(16'h0000);
      kind = int'($urandom_range(0, 9));
      a = {10'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if (kind < 4)      op(1, 0, a, 8'($urandom), 2'($urandom));
      else if (kind < 8) op(0, 1, a, 8'($urandom), 2'($urandom));
      else if (kind < 9) op(0, 0, a, 8'($urandom), 2'($urandom));
      else               op(1, 1, a, 8'($urandom), 2'($urandom));
    end

    done = 1'b1;
  end

endmodule
